pattern_sweeper: RTL and testbench
==================================

PATTERN_SWEEPER -- requirements
Module: pattern_sweeper

Parameters
REQ-001 The block SHALL have parameter N, default 3, meaning the stimulus width in bits (legal range 1..8).
REQ-002 The block SHALL have parameter DWELL, default 10, meaning the clock cycles each pattern is held (legal range 1..255).
REQ-003 The block SHALL have parameter GRAY, default 0, meaning sweep order: 0 binary ascending, 1 reflected Gray code.

Interface
REQ-004 clk  input  1  the single clock; all state changes on its rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  one-cycle request to begin a sweep.
REQ-007 abort  input  1  one-cycle request to cancel a running sweep.
REQ-008 expected  input  2^N  golden truth table; bit k is the expected DUT output for stimulus value k.
REQ-009 stim  output  N  stimulus vector driven to the DUT (bit N-1 = A, MSB).
REQ-010 f_in  input  1  DUT response to stim.
REQ-011 busy  output  1  high while a sweep is running.
REQ-012 done  output  1  one-cycle pulse when a sweep completes without abort.
REQ-013 pass  output  1  high when the last completed sweep matched expected in every entry.
REQ-014 truth  output  2^N  captured truth table; bit k is f_in sampled for stimulus value k.
REQ-015 fail_idx  output  N  stimulus value of the first mismatch in sweep order.
REQ-016 fail_cnt  output  N+1  number of mismatching entries in the last sweep.

Function
REQ-017 The FSM SHALL have states IDLE, RUN and DONE.
REQ-018 IDLE -> RUN SHALL occur on the cycle after start=1 with abort=0; stim SHALL show the first pattern (0) in that first RUN cycle.
REQ-019 On the IDLE -> RUN transition, the block SHALL clear truth, fail_cnt and fail_idx, and SHALL clear pass.
REQ-020 Each pattern SHALL be held on stim for exactly DWELL consecutive cycles; a dwell counter SHALL run 0..DWELL-1.
REQ-021 f_in SHALL be sampled on the cycle the dwell counter equals DWELL-1 and written to truth[stim].
REQ-022 The sample SHALL be compared with expected[stim]; on mismatch fail_cnt SHALL increment, and fail_idx SHALL load stim only on the first mismatch.
REQ-023 Sweep index i SHALL run 0..2^N-1 and SHALL increment on the sample cycle.
REQ-024 stim SHALL equal i when GRAY=0 and SHALL equal i XOR (i>>1) when GRAY=1.
REQ-025 After the sample of index 2^N-1 the FSM SHALL enter DONE; total RUN length SHALL be DWELL*2^N cycles.
REQ-026 In DONE, done SHALL be 1 for exactly one cycle, busy SHALL be 0, pass SHALL be set to (fail_cnt==0), and the FSM SHALL return to IDLE.
REQ-027 busy SHALL be 1 in RUN only.
REQ-028 In IDLE and DONE, stim SHALL be 0.
REQ-029 truth, pass, fail_idx and fail_cnt SHALL hold their values from DONE until the next accepted start.
REQ-030 start SHALL be ignored in RUN and DONE.
REQ-031 abort in RUN SHALL return the FSM to IDLE on the next cycle, with busy=0, stim=0, pass=0 and no done pulse; truth holds the partial capture.
REQ-032 When start and abort are high in the same IDLE cycle, abort SHALL win and the FSM SHALL stay in IDLE.
REQ-033 expected SHALL be treated as static during RUN; changes made during RUN affect only entries compared afterwards.
REQ-034 The index and dwell counters SHALL not wrap: the terminal values end the sweep.

Reset
REQ-035 While rst_n=0, the block SHALL force, asynchronously: state=IDLE, stim=0, busy=0, done=0, pass=0, truth=0, fail_idx=0, fail_cnt=0 and all counters to 0.
REQ-036 Reset mid-sweep SHALL abandon the sweep with no done pulse.
REQ-037 Operation SHALL resume on the first rising edge of clk after rst_n deasserts.

Verification
REQ-038 N=3, DWELL=10, GRAY=0, f_in = A&B|C model, expected=8'b11101010, start -> stim 0..7 each held 10 cycles, done pulses 80 cycles after the first RUN cycle, pass=1, truth=8'hEA, fail_cnt=0.
REQ-039 Same setup with expected=8'hEB -> pass=0, fail_cnt=1, fail_idx=0.
REQ-040 GRAY=1, N=3, DWELL=1 -> stim sequence 0,1,3,2,6,7,5,4; truth indexed by stim value matches the model; done after 8 RUN cycles.
REQ-041 abort at RUN cycle 25 (N=3, DWELL=10) -> next cycle busy=0, stim=0, no done pulse; truth bits 0 and 1 captured, other bits 0.
REQ-042 rst_n low mid-sweep -> all outputs 0 immediately (no clock edge); subsequent start runs a full clean sweep.
REQ-043 start held high through RUN, and start+abort in the same IDLE cycle -> no restart, sweep length unchanged; simultaneous pair leaves busy=0.

Source files
------------

// File: rtl/pattern_sweeper.sv
// pattern_sweeper: steps an N-bit stimulus through every value (binary or
// reflected Gray order), holds each value for DWELL cycles, samples the DUT
// response at the end of each hold and compares it with a golden truth table.
module pattern_sweeper #(
   parameter int N     = 3,
   parameter int DWELL = 10,
   parameter bit GRAY  = 1'b0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              abort,
   input  logic [(1<<N)-1:0] expected,
   output logic [N-1:0]      stim,
   input  logic              f_in,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic [(1<<N)-1:0] truth,
   output logic [N-1:0]      fail_idx,
   output logic [N:0]        fail_cnt
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [7:0] DWELL_LAST = 8'(DWELL - 1);

   state_t         state_q, state_d;
   logic [7:0]     dwell_q;
   logic [N-1:0]   idx_q;
   logic [N-1:0]   stim_code;
   logic           sample;
   logic           last_idx;
   logic           mismatch;
   logic           accept;

   // Sweep index to stimulus code; Gray order is i ^ (i >> 1).
   assign stim_code = GRAY ? (idx_q ^ (idx_q >> 1)) : idx_q;
   assign accept    = start && !abort;
   assign sample    = (state_q == RUN) && !abort && (dwell_q == DWELL_LAST);
   assign last_idx  = (idx_q == {N{1'b1}});
   assign mismatch  = (f_in != expected[stim_code]);

   // Outputs decode straight from the registered state, so they follow reset
   // asynchronously and never lag the state by a cycle.
   assign stim = (state_q == RUN) ? stim_code : '0;
   assign busy = (state_q == RUN);
   assign done = (state_q == DONE);

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: sequential state uses non-blocking (<=) so every register
      // samples the pre-edge values of the others, independent of order.
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Next-state logic: abort beats start in IDLE and ends a running sweep.
   always_comb begin
      // NOTE: default first, so no path through the case leaves state_d
      // unassigned and infers a latch.
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (accept) state_d = RUN;
         RUN: begin
            if (abort)                    state_d = IDLE;
            else if (sample && last_idx)  state_d = DONE;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Counters, capture and result registers.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: truth is a plain flop vector, not a RAM, so it is reset along
      // with everything else and never shows stale entries after reset.
      if (!rst_n) begin
         dwell_q  <= '0;
         idx_q    <= '0;
         truth    <= '0;
         fail_idx <= '0;
         fail_cnt <= '0;
         pass     <= 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (accept) begin
                  dwell_q  <= '0;
                  idx_q    <= '0;
                  truth    <= '0;
                  fail_idx <= '0;
                  fail_cnt <= '0;
                  pass     <= 1'b0;
               end
            end
            RUN: begin
               if (abort) begin
                  // Partial capture in truth is kept for inspection.
                  dwell_q <= '0;
                  idx_q   <= '0;
                  pass    <= 1'b0;
               end else if (sample) begin
                  truth[stim_code] <= f_in;
                  if (mismatch) begin
                     fail_cnt <= fail_cnt + 1'b1;
                     if (fail_cnt == '0) fail_idx <= stim_code;
                  end
                  dwell_q <= '0;
                  if (last_idx) begin
                     // Verdict includes this final comparison so it is
                     // already valid during the done cycle.
                     idx_q <= '0;
                     pass  <= (fail_cnt == '0) && !mismatch;
                  end else begin
                     idx_q <= idx_q + 1'b1;
                  end
               end else begin
                  dwell_q <= dwell_q + 8'd1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_pattern_sweeper.sv
// Self-checking bench for pattern_sweeper: one binary-order instance
// (N=3, DWELL=10) and one Gray-order instance (N=3, DWELL=1), each driving a
// combinational DUT model that looks up its response in a truth table.
module tb_pattern_sweeper;

   logic       clk = 1'b0;
   logic       rst_n;

   logic       start0, abort0, start1, abort1;
   logic [7:0] exp0, exp1, tt0, tt1;
   logic [2:0] stim0, stim1, fidx0, fidx1;
   logic       f_in0, f_in1;
   logic       busy0, busy1, done0, done1, pass0, pass1;
   logic [7:0] truth0, truth1;
   logic [3:0] fcnt0, fcnt1;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   // Device-under-test models: response is the truth-table entry at stim.
   assign f_in0 = tt0[stim0];
   assign f_in1 = tt1[stim1];

   pattern_sweeper #(.N(3), .DWELL(10), .GRAY(1'b0)) dut0 (
      .clk(clk), .rst_n(rst_n), .start(start0), .abort(abort0),
      .expected(exp0), .stim(stim0), .f_in(f_in0), .busy(busy0),
      .done(done0), .pass(pass0), .truth(truth0), .fail_idx(fidx0),
      .fail_cnt(fcnt0));

   pattern_sweeper #(.N(3), .DWELL(1), .GRAY(1'b1)) dut1 (
      .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1),
      .expected(exp1), .stim(stim1), .f_in(f_in1), .busy(busy1),
      .done(done1), .pass(pass1), .truth(truth1), .fail_idx(fidx1),
      .fail_cnt(fcnt1));

   // Selected-instance view used by the generic sweep task.
   logic       sel;
   logic [2:0] c_stim, c_fidx;
   logic       c_busy, c_done, c_pass;
   logic [7:0] c_truth;
   logic [3:0] c_fcnt;
   assign c_stim  = sel ? stim1  : stim0;
   assign c_busy  = sel ? busy1  : busy0;
   assign c_done  = sel ? done1  : done0;
   assign c_pass  = sel ? pass1  : pass0;
   assign c_truth = sel ? truth1 : truth0;
   assign c_fidx  = sel ? fidx1  : fidx0;
   assign c_fcnt  = sel ? fcnt1  : fcnt0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
      end
   endtask

   task automatic set_start(input logic v);
      if (sel) start1 = v; else start0 = v;
   endtask

   // Stimulus value at sweep step i, straight from the ordering rule.
   function automatic logic [31:0] model_stim(input int i, input bit gray);
      return gray ? 32'(i ^ (i >> 1)) : 32'(i);
   endfunction

   // A&B|C with A the MSB of the stimulus.
   function automatic logic [7:0] abc_table();
      logic [7:0] t;
      for (int k = 0; k < 8; k++) begin
         logic [2:0] kv;
         kv   = 3'(k);
         t[k] = (kv[2] & kv[1]) | kv[0];
      end
      return t;
   endfunction

   // Full sweep on the selected instance, checked against a table-level model.
   task automatic sweep(input bit s, input logic [7:0] tt_v, input logic [7:0] exp_v,
                        input bit hold);
      int         dw, c, m_cnt;
      logic [2:0] m_idx;
      bit         found;
      dw  = s ? 1 : 10;
      sel = s;
      if (s) begin tt1 = tt_v; exp1 = exp_v; end
      else   begin tt0 = tt_v; exp0 = exp_v; end
      m_cnt = 0; m_idx = '0; found = 1'b0;
      for (int i = 0; i < 8; i++) begin
         int k;
         k = int'(model_stim(i, s));
         if (tt_v[k] !== exp_v[k]) begin
            m_cnt++;
            if (!found) begin found = 1'b1; m_idx = 3'(k); end
         end
      end
      set_start(1'b1);
      @(negedge clk);
      if (!hold) set_start(1'b0);
      c = 0;
      while (c_busy === 1'b1 && c < 4000) begin
         check("stim_seq", c_stim, model_stim(c / dw, s));
         c++;
         @(negedge clk);
      end
      set_start(1'b0);
      check("run_len", c, dw * 8);
      check("done_pulse", c_done, 1);
      check("busy_in_done", c_busy, 0);
      check("stim_in_done", c_stim, 0);
      @(negedge clk);
      check("done_one_cycle", c_done, 0);
      check("no_restart", c_busy, 0);
      check("pass", c_pass, (m_cnt == 0) ? 1 : 0);
      check("truth", c_truth, tt_v);
      check("fail_cnt", c_fcnt, m_cnt);
      check("fail_idx", c_fidx, m_idx);
   endtask

   initial begin
      logic [7:0] r_tt, r_exp, t_ea;
      bit         done_seen;
      t_ea  = abc_table();
      sel   = 1'b0;
      rst_n = 1'b0;
      start0 = 0; abort0 = 0; start1 = 0; abort1 = 0;
      exp0 = '0; exp1 = '0; tt0 = '0; tt1 = '0;

      // Reset state.
      repeat (3) @(negedge clk);
      check("rst_stim", stim0, 0);
      check("rst_busy", busy0, 0);
      check("rst_done", done0, 0);
      check("rst_pass", pass0, 0);
      check("rst_truth", truth0, 0);
      check("rst_fcnt", fcnt0, 0);
      rst_n = 1'b1;
      @(negedge clk);

      // Directed: A&B|C, matching and one-off golden tables.
      check("abc_table", t_ea, 8'hEA);
      sweep(1'b0, t_ea, 8'b1110_1010, 1'b0);
      sweep(1'b0, t_ea, 8'hEB, 1'b0);

      // Gray order, single-cycle dwell.
      sweep(1'b1, t_ea, t_ea, 1'b0);

      // start held high throughout RUN: no restart, same length.
      sweep(1'b0, 8'($urandom), 8'($urandom), 1'b1);

      // start and abort together in IDLE: abort wins.
      sel = 1'b0;
      start0 = 1'b1; abort0 = 1'b1;
      @(negedge clk);
      check("start_abort_busy", busy0, 0);
      start0 = 1'b0; abort0 = 1'b0;
      @(negedge clk);
      check("start_abort_idle", busy0, 0);

      // Abort at RUN cycle 25: partial capture of entries 0 and 1.
      tt0 = 8'($urandom) | 8'h03; exp0 = 8'($urandom);
      start0 = 1'b1;
      @(negedge clk);
      start0 = 1'b0;
      repeat (25) @(negedge clk);
      abort0 = 1'b1;
      @(negedge clk);
      abort0 = 1'b0;
      check("abort_busy", busy0, 0);
      check("abort_stim", stim0, 0);
      check("abort_pass", pass0, 0);
      done_seen = (done0 === 1'b1);
      repeat (100) begin
         @(negedge clk);
         if (done0 === 1'b1) done_seen = 1'b1;
      end
      check("abort_no_done", done_seen, 0);
      check("abort_stays_idle", busy0, 0);
      check("abort_truth", truth0, {6'b0, tt0[1:0]});

      // Asynchronous reset mid-sweep, then a clean full sweep.
      tt0 = t_ea; exp0 = 8'h15;
      start0 = 1'b1;
      @(negedge clk);
      start0 = 1'b0;
      repeat (45) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("arst_stim", stim0, 0);
      check("arst_busy", busy0, 0);
      check("arst_done", done0, 0);
      check("arst_pass", pass0, 0);
      check("arst_truth", truth0, 0);
      check("arst_fidx", fidx0, 0);
      check("arst_fcnt", fcnt0, 0);
      @(negedge clk);
      #2 rst_n = 1'b1;
      @(negedge clk);
      check("post_rst_idle", busy0, 0);
      sweep(1'b0, t_ea, t_ea, 1'b0);

      // Randomized sweeps on both instances.
      for (int n = 0; n < 8; n++) begin
         r_tt  = 8'($urandom);
         r_exp = ($urandom_range(0, 2) == 0) ? r_tt : 8'($urandom);
         sweep(n[0], r_tt, r_exp, ($urandom_range(0, 3) == 0));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
